// File: rtl/div_ctrl_if.sv
// Execute-stage <-> divide sequencer handshake bundle.
// Carries the operands, the start/annul controls and the {remainder, quotient} result.
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic               annul_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   operand_1_i;
    logic [WIDTH-1:0]   operand_2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stall_req_o;

    modport master (
        output start_i, annul_i, signed_div_i, operand_1_i, operand_2_i,
        input  result_o, ready_o, stall_req_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, operand_1_i, operand_2_i,
        output result_o, ready_o, stall_req_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divide sequencer for DIV/DIVU.
// It runs one iteration per cycle and produces {remainder, quotient} plus a pipeline stall request.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   divisor_r;
    logic               neg_q_r;
    logic               neg_rem_r;
    logic [2*WIDTH-1:0] result_r;
    logic               ready_r;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH+1:0]   trial_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic               stall_s;

    function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] x);
        return (~x) + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic use_sign);
        return (use_sign && x[WIDTH-1]) ? neg2(x) : x;
    endfunction

    // Trial subtraction, sign fix-up and the stall request.
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = {1'b0, shifted_s} - {2'b00, divisor_r};
        quo_fix_s = neg_q_r   ? neg2(quo_r) : quo_r;
        rem_fix_s = neg_rem_r ? neg2(rem_r) : rem_r;
        if (state_r == ON || state_r == BY_ZERO) begin
            stall_s = 1'b1;
        end else if (state_r == IDLE) begin
            stall_s = bus.start_i & ~bus.annul_i;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Sequencer FSM with the datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= {(2*WIDTH){1'b0}};
            ready_r   <= 1'b0;
        end else if (bus.annul_i) begin
            // Flush wins over both a new request and a finishing divide.
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {(2*WIDTH){1'b0}};
            ready_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r  <= 1'b0;
                    result_r <= {(2*WIDTH){1'b0}};
                    if (bus.start_i) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        rem_r     <= {WIDTH{1'b0}};
                        quo_r     <= mag(bus.operand_1_i, bus.signed_div_i);
                        divisor_r <= mag(bus.operand_2_i, bus.signed_div_i);
                        neg_q_r   <= bus.signed_div_i &
                                     (bus.operand_1_i[WIDTH-1] ^ bus.operand_2_i[WIDTH-1]);
                        neg_rem_r <= bus.signed_div_i & bus.operand_1_i[WIDTH-1];
                        if (bus.operand_2_i == {WIDTH{1'b0}}) begin
                            state_r <= BY_ZERO;
                        end else begin
                            state_r <= ON;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ON: begin
                    if (cnt_r == CNT_W'(WIDTH)) begin
                        result_r <= {rem_fix_s, quo_fix_s};
                        ready_r  <= 1'b1;
                        state_r  <= DONE;
                    end else if (!trial_s[WIDTH+1]) begin
                        rem_r <= trial_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        rem_r <= shifted_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                BY_ZERO: begin
                    result_r <= {(2*WIDTH){1'b0}};
                    ready_r  <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    if (!bus.start_i) begin
                        result_r <= {(2*WIDTH){1'b0}};
                        ready_r  <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    result_r <= {(2*WIDTH){1'b0}};
                    ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result_o    = result_r;
    assign bus.ready_o     = ready_r;
    assign bus.stall_req_o = stall_s;
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases plus random operands.
// Expected results come from plain integer division.
module tb_div_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    div_ctrl_if #(.WIDTH(W)) bus ();
    div_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Full transaction: request, wait for ready, hold, release.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit sgn, input int hold);
        logic [63:0] exp;
        int          n;
        int          exp_lat;
        bit          stall_ok;
        exp     = ref_div(a, b, sgn);
        exp_lat = (b == 32'd0) ? 2 : W + 2;
        bus.operand_1_i  = a;
        bus.operand_2_i  = b;
        bus.signed_div_i = sgn;
        bus.start_i      = 1'b1;
        #1;
        check_eq("stall_at_request", 64'(bus.stall_req_o), 64'd1);
        n = 0;
        stall_ok = 1'b1;
        while (!bus.ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                bus.operand_1_i = $urandom;
                bus.operand_2_i = $urandom;
            end
            if (!bus.ready_o && !bus.stall_req_o) stall_ok = 1'b0;
        end
        check_eq("latency", 64'(n), 64'(exp_lat));
        check_eq("result", bus.result_o, exp);
        check_eq("stall_busy", 64'(stall_ok), 64'd1);
        check_eq("stall_done", 64'(bus.stall_req_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_result", bus.result_o, exp);
            check_eq("hold_ready", 64'(bus.ready_o), 64'd1);
        end
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check_eq("release_ready", 64'(bus.ready_o), 64'd0);
        check_eq("release_result", bus.result_o, 64'd0);
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.operand_1_i  = 32'd0;
        bus.operand_2_i  = 32'd0;
        #12;
        check_eq("reset_ready", 64'(bus.ready_o), 64'd0);
        check_eq("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_div(32'd100, 32'd7, 1'b0, 0);
        check_eq("model_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'h2, 32'hE});
        do_div(32'hFFFFFFF9, 32'h2, 1'b1, 0);
        do_div(32'hFFFFFFF9, 32'h2, 1'b0, 0);
        do_div(32'h1234, 32'h0, 1'b0, 0);
        do_div(32'h5, 32'h9, 1'b1, 0);
        do_div(32'hFFFFFFFF, 32'h80000001, 1'b0, 0);

        // Flush in the middle of a divide.
        bus.operand_1_i = 32'd1000;
        bus.operand_2_i = 32'd3;
        bus.signed_div_i = 1'b0;
        bus.start_i = 1'b1;
        repeat (11) begin @(posedge clk); #1; end
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        check_eq("annul_ready", 64'(bus.ready_o), 64'd0);
        check_eq("annul_result", bus.result_o, 64'd0);
        check_eq("annul_stall", 64'(bus.stall_req_o), 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.ready_o) n++;
        end
        check_eq("annul_no_ready", 64'(n), 64'd0);
        do_div(32'd50, 32'd5, 1'b0, 0);

        // Asynchronous reset mid-divide.
        bus.operand_1_i = 32'd1000;
        bus.operand_2_i = 32'd7;
        bus.start_i = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        bus.start_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_on_ready", 64'(bus.ready_o), 64'd0);
        check_eq("arst_on_stall", 64'(bus.stall_req_o), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset while a result is held.
        bus.operand_1_i = 32'd100;
        bus.operand_2_i = 32'd7;
        bus.start_i = 1'b1;
        n = 0;
        while (!bus.ready_o && n < 100) begin @(posedge clk); #1; n++; end
        check_eq("pre_arst_result", bus.result_o, {32'h2, 32'hE});
        #2 rst = 1'b1;
        #1;
        check_eq("arst_done_ready", 64'(bus.ready_o), 64'd0);
        check_eq("arst_done_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);

        // Result held while start stays high, then back-to-back request.
        do_div(32'd77, 32'd10, 1'b0, 3);
        do_div(32'd9, 32'd3, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = $urandom_range(1, 15);
            if (i % 7 == 3) rb = 32'd0;
            do_div(ra, rb, 1'($urandom_range(0, 1)), i % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Multi-cycle divide sequencer for the core's DIV/DIVU instructions. It owns the shared restoring-divide datapath and handles the start/annul/ready handshake with the execute stage. While a divide is in flight it raises a pipeline stall request. The result is delivered as {remainder, quotient} for the HI/LO write path.

Parameters:
WIDTH, 32, operand width in bits; iteration count per divide.

Ports:
clk  input  1  core clock; all state changes on rising edge.
rst  input  1  asynchronous active-high reset.
start_i  input  1  divide request; execute stage holds it high until ready_o is seen.
annul_i  input  1  cancel the current divide (pipeline flush/exception).
signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU.
operand_1_i  input  WIDTH  dividend (rs).
operand_2_i  input  WIDTH  divisor (rt).
result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; HI = remainder, LO = quotient.
ready_o  output  1  result_o valid.
stall_req_o  output  1  pipeline stall request (combinational).

Behaviour:
- Reset (asynchronous, any time, including mid-divide): state IDLE, counter 0, internal dividend/remainder registers 0, result_o 0, ready_o 0.
- States: IDLE, BY_ZERO, ON, DONE.
- IDLE: on an edge with start_i=1 and annul_i=0, latch the operands.
  - Divisor == 0 → BY_ZERO.
  - Otherwise → ON, counter 0.
  - If signed_div_i=1, latch |operand_1_i| and |operand_2_i|, plus the sign of each.
  - Operand changes after capture are ignored.
- ON: one restoring iteration per cycle.
  - Shift the {partial remainder, dividend} register left 1.
  - Trial subtract the divisor; if non-negative, keep the difference and set quotient bit 1, else bit 0.
  - counter++.
  - When counter reaches WIDTH, on the next edge apply sign fix-up and register result_o, then → DONE.
    - Quotient is negated if the operand signs differ (signed only).
    - Remainder takes the dividend's sign (signed only).
- BY_ZERO: next edge → DONE with result_o = 0.
- DONE: ready_o=1 and result_o held stable.
  - Remains DONE while start_i=1.
  - start_i=0 → IDLE on the next edge; ready_o=0 and result_o=0 on that edge.
- Latency, counting from the first edge sampling start_i=1:
  - Normal divide: ready_o high after WIDTH+2 edges (34 for WIDTH=32).
  - Divide by zero: ready_o high after 2 edges.
- annul_i=1 in any state: → IDLE next edge, ready_o=0, result_o=0, counter 0. annul has priority over start_i and over completion.
- stall_req_o = (IDLE & start_i & ~annul_i) | ON | BY_ZERO. It is 0 in DONE, so the pipeline advances on the same cycle ready_o is high.
- Special cases:
  - Signed most-negative / -1 (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0, no exception.
  - Dividend magnitude < divisor magnitude: quotient 0, remainder = dividend.
- All arithmetic is WIDTH bits, with a WIDTH+1-bit trial subtraction. Negation is two's complement modulo 2^WIDTH.

Test Plan:
- Unsigned 100/7: hold start_i → ready_o high exactly 34 edges after start; result_o = {0x00000002, 0x0000000E}; stall_req_o high for edges 0..33, low in DONE.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) → result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Same operands unsigned → {0x00000001, 0x7FFFFFFC}.
- Divisor 0 (0x1234/0) → ready_o after 2 edges, result_o = 0. Drop start_i → IDLE, ready_o=0 next edge.
- annul_i pulsed at iteration 10 → IDLE next edge, ready_o never asserts, stall_req_o drops. A new start then completes normally (50/5 → {0, 10}).
- Async rst asserted mid-ON between edges → ready_o=0 and result_o=0 immediately, without waiting for a clock edge. After release, start 0x80000000/0xFFFFFFFF signed → {0x00000000, 0x80000000}.
- Back-to-back: hold start_i 3 extra cycles in DONE → result_o stable. Deassert for 1 cycle, reassert with new operands (9/3 unsigned) → second result {0, 3} after 34 edges.
